qmult: RTL and testbench
========================

# qmult

Sequential signed-magnitude Q15.16 fixed-point multiplier, the multiply counterpart to the team's iterative Q15.16 divider. It uses the same number format:
- bit 31 is the sign;
- bits 30:0 are the unsigned magnitude, with 16 fractional bits.

It runs a shift-add algorithm, one multiplier bit per cycle, and uses an explicit start/busy/valid handshake. It sits in the arithmetic library next to the divider and feeds the same datapaths (scaling, filter coefficients, PID terms).

## Interface
Parameters:
- WIDTH, 31: magnitude width in bits; the operand/result word is WIDTH+1 bits.
- FBITS, 16: number of fractional bits in the magnitude.

Ports:
- clk, input, 1: clock; all logic is on the rising edge.
- rst, input, 1: reset, synchronous and active-high; one clock; no other reset exists.
- start, input, 1: request a multiply; sampled only in IDLE.
- multiplicand, input, 32: operand A, sign-magnitude Q15.16.
- multiplier, input, 32: operand B, sign-magnitude Q15.16.
- product, output reg, 32: result, sign-magnitude Q15.16; holds its value until the next completion.
- valid, output reg, 1: one-cycle pulse when product is updated.
- busy, output reg, 1: high while an operation is in progress.
- ovf, output reg, 1: overflow flag, set with valid when the result saturated; holds until the next completion.

## Operation
- FSM states:
  - IDLE: busy=0.
  - RUN: busy=1; bit counter cnt runs 0..WIDTH-1.
  - DONE: busy=1; result is registered.
- Transitions:
  - IDLE -> RUN when start=1. On that edge, capture the operands:
    - sign_r = A[31]^B[31];
    - mcand_r = A[30:0];
    - mplier_r = B[30:0];
    - acc (2*WIDTH bits) = 0;
    - cnt = 0.
  - RUN, each cycle:
    - if mplier_r[0]=1, add mcand_r << cnt to acc;
    - then shift mplier_r right by 1 and increment cnt.
  - RUN -> DONE after the iteration with cnt=WIDTH-1, which is WIDTH iterations in total.
  - DONE -> IDLE unconditionally.
- Early termination is not permitted. Latency is fixed regardless of operand values.
- Result formation in DONE, with P = acc (62 bits):
  - mag = P[FBITS+WIDTH-1:FBITS], i.e. P[46:16]. Discarded fraction bits P[15:0] are truncated with no rounding.
  - Overflow when P[2*WIDTH-1:FBITS+WIDTH] (P[61:47]) is nonzero. Then mag = all ones (0x7FFFFFFF) and ovf=1; otherwise ovf=0.
  - If mag==0, sign is forced to 0: negative zero never leaves the block.
  - product = {sign, mag}; valid=1 for exactly this one cycle.
- Operands are captured at start. Input changes while busy have no effect.
- start while busy (RUN or DONE) is ignored and not queued.
- start is level-sampled in IDLE, so holding it high launches back-to-back operations.
- A zero operand is legal: it yields 0x00000000 with ovf=0 and no warning (unlike division).

## Timing
- Reset values: product=0, valid=0, busy=0, ovf=0, FSM=IDLE, cnt=0, acc=0.
- Cycle numbering: start is sampled high at edge k.
  - busy=1 from after edge k.
  - RUN occupies edges k+1..k+31.
  - DONE is entered at edge k+31.
  - At edge k+32: product, ovf and valid are registered, and the FSM returns to IDLE.
  - After edge k+32: valid=1 and busy=0 in the same cycle.
- Latency is 32 cycles from the start sample to valid; in general WIDTH+1.
- Throughput: a new start may be sampled in the cycle where valid=1, so one result every 33 cycles.
- rst during RUN or DONE: at the next edge all registers return to their reset values and the operation is aborted. No valid pulse follows; product reads 0.
- rst and start high on the same edge: reset wins and the FSM stays in IDLE.

## Test plan
- 2.0 x 3.0: A=0x00020000, B=0x00030000 -> product=0x00060000, ovf=0, valid exactly 32 cycles after start.
- -1.5 x 2.0 and 0.5 x 0.5:
  - 0x80018000 x 0x00020000 -> 0x80030000;
  - 0x00008000 x 0x00008000 -> 0x00004000.
- Saturation, 256 x 256:
  - 0x01000000 x 0x01000000 -> 0x7FFFFFFF, ovf=1;
  - 0x81000000 x 0x01000000 -> 0xFFFFFFFF, ovf=1.
- Zero and truncation:
  - 0x80000000 x 0x00010000 -> 0x00000000 (sign cleared);
  - 0x00000001 x 0x00000001 -> 0x00000000, ovf=0.
- Handshake:
  - pulse start again mid-RUN and change the operands -> the first result is unaffected and no second valid appears;
  - hold start high -> valid pulses every 33 cycles.
- Reset mid-operation: assert rst at cycle 10 of RUN -> busy=0, product=0, no valid. A subsequent 2.0 x 3.0 yields 0x00060000.

Source files
------------

// File: rtl/qmult_if.sv
// Start/busy/valid handshake bundle for the sequential Q15.16 multiplier.
// The master launches operations; the slave (qmult) returns the result.
interface qmult_if #(
  parameter int WIDTH = 31
);
  logic             start;
  logic [WIDTH:0]   multiplicand;
  logic [WIDTH:0]   multiplier;
  logic [WIDTH:0]   product;
  logic             valid;
  logic             busy;
  logic             ovf;

  modport master (
    output start, multiplicand, multiplier,
    input  product, valid, busy, ovf
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output product, valid, busy, ovf
  );
endinterface

// File: rtl/qmult.sv
// Sequential sign-magnitude Q15.16 multiplier: shift-add, one multiplier bit
// per cycle, fixed WIDTH+1 cycle latency, saturating on integer overflow.
module qmult #(
  parameter int WIDTH = 31,
  parameter int FBITS = 16
) (
  input logic  clk,
  input logic  rst,
  qmult_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               sign_r;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   mplier_r;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      cnt;

  logic [WIDTH-1:0]   mag_raw;
  logic [WIDTH-1:0]   mag;
  logic               ovf_c;
  logic               sign_c;
  logic [2*WIDTH-1:0] addend;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Result formation: truncate the low fraction bits, saturate when any bit
  // above the Q15.16 integer range is set, and never emit negative zero.
  always_comb begin
    addend  = {{WIDTH{1'b0}}, mcand_r} << cnt;
    mag_raw = acc[FBITS+WIDTH-1:FBITS];
    ovf_c   = |acc[2*WIDTH-1:FBITS+WIDTH];
    mag     = ovf_c ? {WIDTH{1'b1}} : mag_raw;
    sign_c  = sign_r & (mag != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_r      <= 1'b0;
      mcand_r     <= '0;
      mplier_r    <= '0;
      acc         <= '0;
      cnt         <= '0;
      bus.product <= '0;
      bus.valid   <= 1'b0;
      bus.busy    <= 1'b0;
      bus.ovf     <= 1'b0;
    end else begin
      bus.valid <= 1'b0;
      bus.busy  <= (state_nxt != IDLE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign_r   <= bus.multiplicand[WIDTH] ^ bus.multiplier[WIDTH];
            mcand_r  <= bus.multiplicand[WIDTH-1:0];
            mplier_r <= bus.multiplier[WIDTH-1:0];
            acc      <= '0;
            cnt      <= '0;
          end
        end
        RUN: begin
          if (mplier_r[0]) acc <= acc + addend;
          mplier_r <= mplier_r >> 1;
          cnt      <= cnt + CW'(1);
        end
        DONE: begin
          bus.product <= {sign_c, mag};
          bus.ovf     <= ovf_c;
          bus.valid   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_qmult.sv
// Directed-vector bench for qmult: arithmetic results, saturation, latency,
// handshake robustness and mid-operation reset.
module tb_qmult;

  logic clk;
  logic rst;
  int   checkCount;
  int   passCount;

  qmult_if #(.WIDTH(31)) bus ();

  qmult #(.WIDTH(31), .FBITS(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h",
                  tag, observed, expected);
  endtask

  // lat counts clock edges after the one that samples start until valid is seen.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] prod, output logic ovfOut,
                               output int lat);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 0;
    while (!bus.valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    prod   = bus.product;
    ovfOut = bus.ovf;
  endtask

  logic [31:0] vecA  [7] = '{32'h00020000, 32'h80018000, 32'h00008000,
                             32'h01000000, 32'h81000000, 32'h80000000,
                             32'h00000001};
  logic [31:0] vecB  [7] = '{32'h00030000, 32'h00020000, 32'h00008000,
                             32'h01000000, 32'h01000000, 32'h00010000,
                             32'h00000001};
  logic [31:0] vecP  [7] = '{32'h00060000, 32'h80030000, 32'h00004000,
                             32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000,
                             32'h00000000};
  logic        vecO  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  initial begin
    logic [31:0] prod;
    logic        ovfOut;
    int          lat;
    int          valids;
    int          firstAt;
    int          secondAt;
    int          n;

    checkCount = 0;
    passCount  = 0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    repeat (2) @(negedge clk);
    checkOutput("reset_product", bus.product, 32'h0);
    checkOutput("reset_valid", {31'b0, bus.valid}, 32'h0);
    checkOutput("reset_busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("reset_ovf", {31'b0, bus.ovf}, 32'h0);
    rst = 1'b0;

    // busy must rise right after the start sample
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 32'h00020000;
    bus.multiplier = 32'h00030000;
    @(negedge clk);
    bus.start = 1'b0;
    checkOutput("busy_after_start", {31'b0, bus.busy}, 32'h1);
    n = 0;
    while (!bus.valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("busy_low_with_valid", {31'b0, bus.busy}, 32'h0);
    checkOutput("valid_seen", {31'b0, bus.valid}, 32'h1);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecA[i], vecB[i], prod, ovfOut, lat);
      checkOutput($sformatf("vec%0d_product", i), prod, vecP[i]);
      checkOutput($sformatf("vec%0d_ovf", i), {31'b0, ovfOut}, {31'b0, vecO[i]});
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'd32);
    end

    // start pulsed mid-RUN with new operands must be ignored
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 32'h00020000;
    bus.multiplier = 32'h00030000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 32'h00050000;
    bus.multiplier = 32'h00070000;
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!bus.valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("midrun_product", bus.product, 32'h00060000);
    valids = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid) valids++;
    end
    checkOutput("midrun_no_second_valid", 32'(valids), 32'd0);

    // holding start launches back-to-back operations
    bus.multiplicand = 32'h00020000;
    bus.multiplier = 32'h00030000;
    bus.start = 1'b1;
    firstAt = -1;
    secondAt = -1;
    for (int c = 0; c < 100 && secondAt < 0; c++) begin
      @(negedge clk);
      if (bus.valid) begin
        if (firstAt < 0) firstAt = c;
        else secondAt = c;
      end
    end
    bus.start = 1'b0;
    checkOutput("hold_interval", 32'(secondAt - firstAt), 32'd33);
    checkOutput("hold_product", bus.product, 32'h00060000);
    n = 0;
    while ((bus.busy || bus.valid) && n < 60) begin
      @(negedge clk);
      n++;
    end
    checkOutput("hold_drained", {31'b0, bus.busy}, 32'h0);

    // reset in cycle 10 of RUN aborts the operation
    @(negedge clk);
    bus.start = 1'b1;
    bus.multiplicand = 32'h00020000;
    bus.multiplier = 32'h00030000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_busy", {31'b0, bus.busy}, 32'h0);
    checkOutput("abort_product", bus.product, 32'h0);
    valids = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid) valids++;
    end
    checkOutput("abort_no_valid", 32'(valids), 32'd0);
    applyStimulus(32'h00020000, 32'h00030000, prod, ovfOut, lat);
    checkOutput("after_abort_product", prod, 32'h00060000);
    checkOutput("after_abort_latency", 32'(lat), 32'd32);

    // reset wins over a simultaneous start
    @(negedge clk);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    checkOutput("rst_beats_start_busy", {31'b0, bus.busy}, 32'h0);
    @(negedge clk);
    checkOutput("rst_beats_start_idle", {31'b0, bus.busy}, 32'h0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
